led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencer/controller for the 8-bit LED output bank of tt_um_led_jellyant.
//   Holds a small writable pattern table and steps through it. Each step shows
//   one 8-bit LED pattern for a programmable number of prescaled ticks.
//   Sits between the ui_in/uio_in config decode and the uo_out driver.
//   Supports loop and one-shot playback.
// PARAMETERS
//   STEPS      8   number of pattern-table entries (power of two)
//   AW         3   table address width, log2(STEPS)
//   PRESCALE_W 16  prescaler counter width
//   DWELL_W    8   per-step dwell counter width (in ticks)
// PORTS
//   clk        in   1            system clock
//   rst        in   1            asynchronous reset, active-high
//   ena        in   1            design enable; low = freeze all counters/state
//   start      in   1            1-cycle pulse: begin playback at step 0
//   stop       in   1            1-cycle pulse: abort playback, blank LEDs
//   oneshot    in   1            1 = play once then stop; 0 = loop; sampled at start
//   prescale   in   PRESCALE_W   tick period minus 1 (0 = tick every cycle)
//   wr_en      in   1            table write strobe
//   wr_addr    in   AW           table write index
//   wr_data    in   DWELL_W+8    {dwell[DWELL_W-1:0], pattern[7:0]}
//   led_out    out  8            registered LED drive
//   step_idx   out  AW           index of the step being displayed
//   busy       out  1            high in RUN
//   done       out  1            1-cycle pulse when a one-shot run completes
// BEHAVIOUR
// - Reset (async, rst=1): table entries=0, led_out=0, step_idx=0, busy=0, done=0,
//   prescaler=0, dwell counter=0, state=IDLE. Reset mid-run aborts at once, no done pulse.
// - States: IDLE -> RUN (start) ; RUN -> IDLE (stop, or one-shot end) ; no other states.
// - Prescaler counts 0..prescale in RUN only, cleared in IDLE. tick = (count==prescale).
//   prescale changed mid-run: if count>prescale, the counter runs on and wraps at
//   2^PRESCALE_W. No early tick.
// - start in IDLE: on the next edge state=RUN, step_idx=0, led_out=pattern[0],
//   dwell_cnt=dwell[0], mode latched. Latency start->led_out valid = 1 cycle.
// - RUN, on tick: if dwell_cnt<=1, advance; else dwell_cnt-=1.
//   Each step holds max(dwell,1) ticks, so dwell=0 behaves as 1.
// - Advance: the next step's pattern/dwell load into led_out/dwell_cnt on the same edge.
//   Wrap step STEPS-1 -> 0 in loop mode.
//   In one-shot mode, advancing past STEPS-1 instead gives: state=IDLE, led_out=0,
//   step_idx=0, busy=0, done=1 for exactly one cycle.
// - stop in RUN: next edge state=IDLE, led_out=0, step_idx=0, busy=0, no done pulse.
//   stop in IDLE has no effect.
// - Priority: rst > stop > tick/advance > start. start while busy is ignored.
//   start+stop in the same cycle: stop wins, so the block stays/returns IDLE.
// - wr_en is accepted in any state; the write lands on the next edge.
//   A write to the currently displayed step does not change led_out or dwell_cnt
//   until that step is next loaded.
// - ena=0: prescaler, dwell_cnt, state and outputs hold. start/stop ignored.
//   Table writes still accepted. done is never asserted while ena=0.
// - All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   LED_SEQ_PWM_EN defined: adds input brightness[3:0].
//     A free-running 4-bit pwm_cnt counts 0..14 (period 15) while ena=1.
//     led_out = pattern & {8{pwm_cnt < brightness}}.
//     brightness=0 gives always off; brightness>=15 gives always on.
//     pwm_cnt resets to 0. Gating is registered, adding 0 extra cycles of latency.
//   Not defined: no brightness port, no pwm_cnt; led_out = pattern directly.
// TESTING
//   T1 reset: assert rst mid-run -> led_out=0, busy=0, done=0 immediately (async).
//      Table reads back 0.
//   T2 loop: table[i]={dwell=2, pattern=8'h01<<i}, prescale=3, oneshot=0, start
//      -> each pattern held 8 cycles; 8'h80 followed by 8'h01; busy stays 1.
//   T3 one-shot: same table, oneshot=1 -> after 64 cycles led_out=0, done high
//      for 1 cycle, busy=0.
//   T4 dwell=0 on step 3, prescale=0 -> step 3 shown for exactly 1 cycle.
//   T5 start+stop in the same cycle from IDLE -> stays IDLE, led_out=0.
//      stop during step 5 -> led_out=0 next cycle, no done.
//   T6 LED_SEQ_PWM_EN, pattern=8'hFF, brightness=5 -> led_out=8'hFF for 5 of
//      every 15 cycles. brightness=0 -> always 0.

Source files
------------

// File: rtl/led_seq_ctrl_if.sv
// LED sequencer bus: control, table-write port and LED/status outputs.
// Optional macro LED_SEQ_PWM_EN adds the brightness input.
interface led_seq_ctrl_if #(
    parameter int unsigned AW         = 3,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned DWELL_W    = 8
);
    logic                  ena;
    logic                  start;
    logic                  stop;
    logic                  oneshot;
    logic [PRESCALE_W-1:0] prescale;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DWELL_W+7:0]    wr_data;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]            brightness;
`endif
    logic [7:0]            led_out;
    logic [AW-1:0]         step_idx;
    logic                  busy;
    logic                  done;

    // Config/decode side: drives controls, observes LED state
    modport master (
`ifdef LED_SEQ_PWM_EN
        output brightness,
`endif
        output ena, start, stop, oneshot, prescale, wr_en, wr_addr, wr_data,
        input  led_out, step_idx, busy, done
    );

    // Sequencer side
    modport slave (
`ifdef LED_SEQ_PWM_EN
        input  brightness,
`endif
        input  ena, start, stop, oneshot, prescale, wr_en, wr_addr, wr_data,
        output led_out, step_idx, busy, done
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps through a writable table of {dwell, pattern} entries,
// showing each pattern for max(dwell,1) prescaled ticks, in loop or one-shot mode.
// Optional macro LED_SEQ_PWM_EN: adds a 15-phase brightness gate on led_out.
module led_seq_ctrl #(
    parameter int unsigned STEPS      = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned DWELL_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    led_seq_ctrl_if.slave bus
);
    localparam int unsigned   ENTRY_W   = DWELL_W + 8;
    localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [ENTRY_W-1:0]    table_q [STEPS];
    logic [PRESCALE_W-1:0] pres_q, pres_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [AW-1:0]         step_q, step_d, step_nx;
    logic [7:0]            pat_q, pat_d;
    logic [7:0]            led_q, led_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  oneshot_q, oneshot_d;
    logic                  tick;
    logic [ENTRY_W-1:0]    first_entry, next_entry;

    assign step_nx     = step_q + AW'(1);
    assign first_entry = table_q[0];
    assign next_entry  = table_q[step_nx];
    assign tick        = (pres_q == bus.prescale);

    // Pattern table: writable in any state, even while frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STEPS; i++) table_q[i] <= '0;
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next-state: stop beats tick/advance beats start; ena=0 holds everything
    always_comb begin
        state_d   = state_q;
        pres_d    = pres_q;
        dwell_d   = dwell_q;
        step_d    = step_q;
        pat_d     = pat_q;
        busy_d    = busy_q;
        oneshot_d = oneshot_q;
        done_d    = 1'b0;
        if (bus.ena) begin
            unique case (state_q)
                IDLE: begin
                    pres_d = '0;
                    if (bus.start && !bus.stop) begin
                        state_d   = RUN;
                        step_d    = '0;
                        pat_d     = first_entry[7:0];
                        dwell_d   = first_entry[ENTRY_W-1:8];
                        oneshot_d = bus.oneshot;
                        busy_d    = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        pres_d  = '0;
                        dwell_d = '0;
                        step_d  = '0;
                        pat_d   = '0;
                        busy_d  = 1'b0;
                    end else if (tick) begin
                        pres_d = '0;
                        if (dwell_q <= DWELL_W'(1)) begin
                            if (oneshot_q && (step_q == LAST_STEP)) begin
                                state_d = IDLE;
                                dwell_d = '0;
                                step_d  = '0;
                                pat_d   = '0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                step_d  = step_nx;
                                pat_d   = next_entry[7:0];
                                dwell_d = next_entry[ENTRY_W-1:8];
                            end
                        end else begin
                            dwell_d = dwell_q - DWELL_W'(1);
                        end
                    end else begin
                        // Wraps naturally if prescale dropped below the count
                        pres_d = pres_q + PRESCALE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_q, pwm_d;
    logic       pwm_on;

    assign pwm_on = (pwm_d < bus.brightness);

    // Free-running 15-phase PWM counter and gated LED value
    always_comb begin
        pwm_d = pwm_q;
        led_d = led_q;
        if (bus.ena) begin
            pwm_d = (pwm_q == 4'd14) ? 4'd0 : pwm_q + 4'd1;
            led_d = pat_d & {8{pwm_on}};
        end
    end

    // PWM counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end
`else
    // LED value follows the current pattern directly
    always_comb begin
        led_d = led_q;
        if (bus.ena) led_d = pat_d;
    end
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pres_q    <= '0;
            dwell_q   <= '0;
            step_q    <= '0;
            pat_q     <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pres_q    <= pres_d;
            dwell_q   <= dwell_d;
            step_q    <= step_d;
            pat_q     <= pat_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            oneshot_q <= oneshot_d;
        end
    end

    assign bus.led_out  = led_q;
    assign bus.step_idx = step_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: expected per-cycle {done,busy,step,led}
// words are queued from the table contents and timing rules, then popped and
// compared on each falling edge. Build with +define+LED_SEQ_PWM_EN for PWM checks.
module tb_led_seq_ctrl;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic rst;

    led_seq_ctrl_if bus_if ();
    led_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;

    typedef struct packed {
        logic          done;
        logic          busy;
        logic [AW-1:0] step;
        logic [7:0]    led;
    } obs_t;

    obs_t        exp_q [$];
    logic [15:0] model_tab [8];
    int          total = 0;
    int          bad   = 0;
    string       phase = "reset";

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_n(logic [7:0] led, int step, logic busy, logic done, int n);
        obs_t e;
        e.done = done;
        e.busy = busy;
        e.step = AW'(step);
        e.led  = led;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    function automatic int hold(int i, int p);
        int d;
        d = int'(model_tab[i][15:8]);
        if (d == 0) d = 1;
        return d * (p + 1);
    endfunction

    task automatic expect_steps(int first, int last, int p);
        for (int i = first; i <= last; i++)
            expect_n(model_tab[i][7:0], i, 1'b1, 1'b0, hold(i, p));
    endtask

    task automatic drain();
        obs_t e;
        obs_t got;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = {bus_if.done, bus_if.busy, bus_if.step_idx, bus_if.led_out};
            check(phase, 32'(got), 32'(e));
        end
    endtask

    task automatic wr(int addr, logic [7:0] dwell, logic [7:0] pat);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = AW'(addr);
        bus_if.wr_data = {dwell, pat};
        model_tab[addr] = {dwell, pat};
        @(posedge clk);
        #1 bus_if.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        @(posedge clk);
        #1 bus_if.start = 1'b0;
    endtask

    task automatic pulse_stop_expect_idle();
        bus_if.stop = 1'b1;
        @(posedge clk);
        #1 bus_if.stop = 1'b0;
        expect_n(8'h00, 0, 1'b0, 1'b0, 3);
        drain();
    endtask

    task automatic oneshot_run(int p);
        bus_if.oneshot  = 1'b1;
        bus_if.prescale = 16'(p);
        pulse_start();
        expect_steps(0, 7, p);
        expect_n(8'h00, 0, 1'b0, 1'b1, 1);
        expect_n(8'h00, 0, 1'b0, 1'b0, 2);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) model_tab[i] = '0;
        rst            = 1'b1;
        bus_if.ena     = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.stop    = 1'b0;
        bus_if.oneshot = 1'b0;
        bus_if.prescale = '0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
`ifdef LED_SEQ_PWM_EN
        bus_if.brightness = 4'd15;
`endif
        #2;
        check("rst_led",  32'(bus_if.led_out), 32'h0);
        check("rst_busy", 32'(bus_if.busy), 32'h0);
        check("rst_done", 32'(bus_if.done), 32'h0);
        check("rst_step", 32'(bus_if.step_idx), 32'h0);
        #10 rst = 1'b0;

        phase = "idle";
        expect_n(8'h00, 0, 1'b0, 1'b0, 3);
        drain();

        // Empty table: every step shows 0 for one cycle (dwell 0 acts as 1)
        phase = "zero_tab";
        oneshot_run(0);

        // Loop playback, two full laps, then stop at the wrap edge
        for (int i = 0; i < 8; i++) wr(i, 8'd2, 8'(8'h01 << i));
        phase = "loop";
        bus_if.oneshot  = 1'b0;
        bus_if.prescale = 16'd3;
        pulse_start();
        expect_steps(0, 7, 3);
        expect_steps(0, 7, 3);
        drain();
        phase = "loop_stop";
        pulse_stop_expect_idle();

        phase = "oneshot";
        oneshot_run(3);

        // Step 3 with dwell 0 shows for exactly one cycle
        wr(3, 8'd0, 8'h08);
        phase = "dwell0";
        oneshot_run(0);

        // start and stop together from idle: stays idle
        phase = "start_stop";
        bus_if.start = 1'b1;
        bus_if.stop  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        expect_n(8'h00, 0, 1'b0, 1'b0, 3);
        drain();

        // Stop during step 5: blank next cycle, no done
        phase = "stop_step5";
        bus_if.oneshot  = 1'b0;
        bus_if.prescale = 16'd0;
        pulse_start();
        expect_steps(0, 4, 0);
        expect_n(model_tab[5][7:0], 5, 1'b1, 1'b0, 1);
        drain();
        pulse_stop_expect_idle();

        // Freeze with ena=0: stop ignored, write to shown step deferred
        phase = "freeze";
        pulse_start();
        expect_steps(0, 0, 0);
        expect_n(8'h02, 1, 1'b1, 1'b0, 1);
        drain();
        bus_if.ena = 1'b0;
        bus_if.stop = 1'b1;
        bus_if.start = 1'b1;
        wr(1, 8'd2, 8'hAA);
        bus_if.stop  = 1'b0;
        bus_if.start = 1'b0;
        expect_n(8'h02, 1, 1'b1, 1'b0, 4);
        drain();
        bus_if.ena = 1'b1;
        phase = "resume";
        expect_n(8'h02, 1, 1'b1, 1'b0, 1);
        expect_steps(2, 7, 0);
        expect_steps(0, 1, 0);
        expect_n(model_tab[2][7:0], 2, 1'b1, 1'b0, 1);
        drain();
        pulse_stop_expect_idle();

        // Asynchronous reset mid-run clears outputs and the table
        phase = "mid_rst";
        bus_if.prescale = 16'd3;
        pulse_start();
        expect_n(model_tab[0][7:0], 0, 1'b1, 1'b0, 3);
        drain();
        #2 rst = 1'b1;
        #1;
        check("arst_led",  32'(bus_if.led_out), 32'h0);
        check("arst_busy", 32'(bus_if.busy), 32'h0);
        check("arst_done", 32'(bus_if.done), 32'h0);
        check("arst_step", 32'(bus_if.step_idx), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) model_tab[i] = '0;
        phase = "tab_cleared";
        oneshot_run(0);

`ifdef LED_SEQ_PWM_EN
        begin
            int on_cnt;
            int off_cnt;
            for (int i = 0; i < 8; i++) wr(i, 8'd255, 8'hFF);
            bus_if.oneshot    = 1'b0;
            bus_if.prescale   = 16'hFFFF;
            bus_if.brightness = 4'd5;
            pulse_start();
            @(negedge clk);
            on_cnt = 0;
            off_cnt = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (bus_if.led_out == 8'hFF) on_cnt++;
                else if (bus_if.led_out == 8'h00) off_cnt++;
            end
            check("pwm5_on", 32'(on_cnt), 32'd10);
            check("pwm5_off", 32'(off_cnt), 32'd20);
            bus_if.brightness = 4'd0;
            @(negedge clk);
            on_cnt = 0;
            for (int k = 0; k < 15; k++) begin
                @(negedge clk);
                if (bus_if.led_out != 8'h00) on_cnt++;
            end
            check("pwm0_on", 32'(on_cnt), 32'd0);
            bus_if.brightness = 4'd15;
            @(negedge clk);
            on_cnt = 0;
            for (int k = 0; k < 15; k++) begin
                @(negedge clk);
                if (bus_if.led_out == 8'hFF) on_cnt++;
            end
            check("pwm15_on", 32'(on_cnt), 32'd15);
            phase = "pwm_stop";
            pulse_stop_expect_idle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
